bp_cce_gpr_wr_arb: RTL and testbench

Write-port arbiter and sequencer for the CCE general-purpose register file. Three writers share the single GPR write port: microcode instructions, the directory RDE address return, and a config-link debug agent. The debug agent can also read GPRs. Microcode has priority. A starvation counter forces a one-cycle microcode stall so the other writers always make progress. The block sits between the CCE decoder/directory/cfg-link and the GPR storage, and drives that storage's write mask and data.

---
 rtl/bp_cce_pkg.sv | 13 +
 rtl/bp_cce_gpr_wr_rr.sv | 38 +++
 rtl/bp_cce_gpr_wr_arb.sv | 154 +++++++++++++++
 tb/tb_bp_cce_gpr_wr_arb.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared types for the CCE GPR write-port arbiter.
// The round-robin request/grant bit positions are defined here.
package bp_cce_pkg;

  typedef enum logic [0:0] {
    e_idle = 1'b0,
    e_resp = 1'b1
  } bp_cce_gpr_wr_arb_state_e;

  localparam int rr_dir_lp = 0;
  localparam int rr_cfg_lp = 1;

endpackage

// File: rtl/bp_cce_gpr_wr_rr.sv
// Two-way round-robin arbiter between the directory and cfg-write agents.
// rr_r = 0 favours the directory; after a grant it points at the other agent.
module bp_cce_gpr_wr_rr
  import bp_cce_pkg::*;
(
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  logic rr_r;

  // Grant selection; a conflict is resolved by rr_r.
  always_comb begin
    gnt_o = 2'b00;
    if (!en_i) begin
      gnt_o = 2'b00;
    end else if (req_i == 2'b11) begin
      gnt_o = rr_r ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
  end

  // Pointer update.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_r <= 1'b0;
    end else if (gnt_o[rr_dir_lp]) begin
      rr_r <= 1'b1;
    end else if (gnt_o[rr_cfg_lp]) begin
      rr_r <= 1'b0;
    end
  end

endmodule

// File: rtl/bp_cce_gpr_wr_arb.sv
// Single GPR write-port arbiter for ucode, directory and cfg-link debug writers.
// A starvation counter forces a one-cycle ucode stall so the other writers make progress.
module bp_cce_gpr_wr_arb
  import bp_cce_pkg::*;
#(
  parameter int num_gpr_p      = 8,
  parameter int gpr_width_p    = 64,
  parameter int paddr_width_p  = 40,
  parameter int starve_limit_p = 4
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic                                  ucode_w_v_i,
  input  logic [num_gpr_p-1:0]                  ucode_w_mask_i,
  input  logic [gpr_width_p-1:0]                ucode_w_data_i,
  output logic                                  ucode_stall_o,
  input  logic                                  dir_v_i,
  input  logic [$clog2(num_gpr_p)-1:0]          dir_gpr_sel_i,
  input  logic [paddr_width_p-1:0]              dir_addr_i,
  output logic                                  dir_yumi_o,
  input  logic                                  cfg_v_i,
  input  logic                                  cfg_w_i,
  input  logic [$clog2(num_gpr_p)-1:0]          cfg_gpr_sel_i,
  input  logic [gpr_width_p-1:0]                cfg_data_i,
  output logic                                  cfg_ready_o,
  output logic                                  cfg_resp_v_o,
  output logic [gpr_width_p-1:0]                cfg_resp_data_o,
  input  logic                                  cfg_resp_yumi_i,
  input  logic [num_gpr_p-1:0][gpr_width_p-1:0] gpr_i,
  output logic [num_gpr_p-1:0]                  gpr_w_mask_o,
  output logic [gpr_width_p-1:0]                gpr_w_data_o
);

  localparam int starve_width_lp = $clog2(starve_limit_p + 1);
  localparam logic [starve_width_lp-1:0] starve_limit_lp = starve_width_lp'(starve_limit_p);
  localparam logic [starve_width_lp-1:0] starve_one_lp   = starve_width_lp'(1);

  function automatic logic [num_gpr_p-1:0] one_hot(input logic [$clog2(num_gpr_p)-1:0] sel);
    return num_gpr_p'(1) << sel;
  endfunction

  bp_cce_gpr_wr_arb_state_e    state_r, state_n;
  logic [starve_width_lp-1:0]  starve_r, starve_inc_s;
  logic                        ucode_stall_r;
  logic [gpr_width_p-1:0]      resp_data_r;
  logic                        cfg_wr_elig_s, ucode_gnt_s, dir_gnt_s, cfg_gnt_s;
  logic                        lose_s, accept_s;
  logic [1:0]                  rr_req_s, rr_gnt_s;

  // Grants are gated by reset so every output reads 0 while reset is held.
  always_comb begin
    cfg_wr_elig_s = (state_r == e_idle) & cfg_v_i & cfg_w_i;
    ucode_gnt_s   = reset_n_i & ucode_w_v_i & ~ucode_stall_r;
    rr_req_s      = {cfg_wr_elig_s, dir_v_i};
  end

  bp_cce_gpr_wr_rr rr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .en_i      (reset_n_i & ~ucode_gnt_s),
    .req_i     (rr_req_s),
    .gnt_o     (rr_gnt_s)
  );

  assign dir_gnt_s    = rr_gnt_s[rr_dir_lp];
  assign cfg_gnt_s    = rr_gnt_s[rr_cfg_lp];
  assign lose_s       = ucode_gnt_s & (dir_v_i | cfg_wr_elig_s);
  assign starve_inc_s = starve_r + starve_one_lp;
  assign accept_s     = cfg_v_i & cfg_ready_o;

  // Write-port mux driven by the single winner.
  always_comb begin
    gpr_w_mask_o = '0;
    gpr_w_data_o = '0;
    if (ucode_gnt_s) begin
      gpr_w_mask_o = ucode_w_mask_i;
      gpr_w_data_o = ucode_w_data_i;
    end else if (dir_gnt_s) begin
      gpr_w_mask_o = one_hot(dir_gpr_sel_i);
      gpr_w_data_o = gpr_width_p'(dir_addr_i);
    end else if (cfg_gnt_s) begin
      gpr_w_mask_o = one_hot(cfg_gpr_sel_i);
      gpr_w_data_o = cfg_data_i;
    end else begin
      gpr_w_mask_o = '0;
      gpr_w_data_o = '0;
    end
  end

  // cfg FSM next state and handshake outputs; reads never need the port.
  always_comb begin
    state_n      = state_r;
    cfg_ready_o  = 1'b0;
    cfg_resp_v_o = 1'b0;
    case (state_r)
      e_idle: begin
        cfg_ready_o = reset_n_i & (~cfg_w_i | cfg_gnt_s);
        if (cfg_v_i & cfg_ready_o) begin
          state_n = e_resp;
        end else begin
          state_n = e_idle;
        end
      end
      e_resp: begin
        cfg_resp_v_o = 1'b1;
        if (cfg_resp_yumi_i) begin
          state_n = e_idle;
        end else begin
          state_n = e_resp;
        end
      end
      default: begin
        state_n = e_idle;
      end
    endcase
  end

  // cfg FSM state and response capture (reads see the pre-write GPR value).
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r     <= e_idle;
      resp_data_r <= '0;
    end else begin
      state_r <= state_n;
      if (accept_s) begin
        resp_data_r <= cfg_w_i ? '0 : gpr_i[cfg_gpr_sel_i];
      end
    end
  end

  // Starvation counter and the registered one-cycle ucode stall.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_r      <= '0;
      ucode_stall_r <= 1'b0;
    end else if (dir_gnt_s | cfg_gnt_s) begin
      starve_r      <= '0;
      ucode_stall_r <= 1'b0;
    end else if (lose_s && (starve_inc_s == starve_limit_lp)) begin
      starve_r      <= '0;
      ucode_stall_r <= 1'b1;
    end else if (lose_s) begin
      starve_r      <= starve_inc_s;
      ucode_stall_r <= 1'b0;
    end else begin
      ucode_stall_r <= 1'b0;
    end
  end

  assign ucode_stall_o   = ucode_stall_r;
  assign dir_yumi_o      = dir_gnt_s;
  assign cfg_resp_data_o = resp_data_r;

endmodule

// File: tb/tb_bp_cce_gpr_wr_arb.sv
// Directed bench for bp_cce_gpr_wr_arb with a transaction-level reference model
// checked every cycle, plus literal expectations from the written scenarios.
module tb_bp_cce_gpr_wr_arb;

  localparam int NG = 8;
  localparam int GW = 64;
  localparam int PW = 40;
  localparam int LIMIT = 4;
  localparam int W_NONE = 0, W_UC = 1, W_DIR = 2, W_CFG = 3;
  localparam logic [NG-1:0][GW-1:0] INIT = {64'h7777, 64'h6666, 64'h5555, 64'h4444,
                                            64'h3333, 64'hDEAD, 64'h1111, 64'h0000};

  logic clk = 1'b0;
  logic rst_n;
  logic ucode_v;
  logic [NG-1:0] ucode_mask;
  logic [GW-1:0] ucode_data;
  logic stall;
  logic dir_v;
  logic [2:0] dir_sel;
  logic [PW-1:0] dir_addr;
  logic dir_yumi;
  logic cfg_v, cfg_w;
  logic [2:0] cfg_sel;
  logic [GW-1:0] cfg_data;
  logic cfg_ready, resp_v, resp_yumi;
  logic [GW-1:0] resp_data;
  logic [NG-1:0][GW-1:0] gpr_q = INIT;
  logic [NG-1:0] w_mask;
  logic [GW-1:0] w_data;

  int n_cmp = 0;
  int n_mis = 0;

  // reference model state
  int m_fav;
  int m_cnt;
  bit m_stall;
  bit m_busy;
  logic [GW-1:0] m_resp;
  logic [NG-1:0][GW-1:0] m_gpr = INIT;

  always #5 clk = ~clk;

  bp_cce_gpr_wr_arb dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .ucode_w_v_i(ucode_v), .ucode_w_mask_i(ucode_mask), .ucode_w_data_i(ucode_data),
    .ucode_stall_o(stall),
    .dir_v_i(dir_v), .dir_gpr_sel_i(dir_sel), .dir_addr_i(dir_addr), .dir_yumi_o(dir_yumi),
    .cfg_v_i(cfg_v), .cfg_w_i(cfg_w), .cfg_gpr_sel_i(cfg_sel), .cfg_data_i(cfg_data),
    .cfg_ready_o(cfg_ready), .cfg_resp_v_o(resp_v), .cfg_resp_data_o(resp_data),
    .cfg_resp_yumi_i(resp_yumi),
    .gpr_i(gpr_q), .gpr_w_mask_o(w_mask), .gpr_w_data_o(w_data)
  );

  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Who owns the write port this cycle, by priority then round-robin.
  function automatic int winner();
    bit wr_ok;
    wr_ok = !m_busy && cfg_v && cfg_w;
    if (ucode_v && !m_stall) return W_UC;
    if (dir_v && wr_ok) return (m_fav == 0) ? W_DIR : W_CFG;
    if (dir_v) return W_DIR;
    if (wr_ok) return W_CFG;
    return W_NONE;
  endfunction

  function automatic logic [NG-1:0] exp_mask(input int w);
    if (w == W_UC) return ucode_mask;
    if (w == W_DIR) return NG'(1) << dir_sel;
    if (w == W_CFG) return NG'(1) << cfg_sel;
    return '0;
  endfunction

  function automatic logic [GW-1:0] exp_data(input int w);
    if (w == W_UC) return ucode_data;
    if (w == W_DIR) return {{(GW-PW){1'b0}}, dir_addr};
    if (w == W_CFG) return cfg_data;
    return '0;
  endfunction

  // GPR storage fed by the DUT write port.
  always @(posedge clk) begin
    for (int i = 0; i < NG; i++) if (w_mask[i]) gpr_q[i] <= w_data;
  end

  // Model state advance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_fav = 0; m_cnt = 0; m_stall = 0; m_busy = 0; m_resp = '0;
    end else begin
      int w;
      bit waiting, rdy;
      w = winner();
      waiting = dir_v || (!m_busy && cfg_v && cfg_w);
      rdy = !m_busy && (!cfg_w || w == W_CFG);
      if (m_busy) begin
        if (resp_yumi) m_busy = 0;
      end else if (cfg_v && rdy) begin
        m_busy = 1;
        m_resp = cfg_w ? '0 : m_gpr[cfg_sel];
      end
      for (int i = 0; i < NG; i++) if (exp_mask(w)[i]) m_gpr[i] = exp_data(w);
      if (w == W_DIR) m_fav = 1;
      if (w == W_CFG) m_fav = 0;
      if (w == W_DIR || w == W_CFG) begin
        m_cnt = 0; m_stall = 0;
      end else if (w == W_UC && waiting) begin
        m_cnt = m_cnt + 1;
        if (m_cnt == LIMIT) begin m_cnt = 0; m_stall = 1; end
        else m_stall = 0;
      end else begin
        m_stall = 0;
      end
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      int w;
      w = winner();
      chk("stall", {63'd0, stall}, {63'd0, m_stall});
      chk("dir_yumi", {63'd0, dir_yumi}, {63'd0, w == W_DIR});
      chk("cfg_ready", {63'd0, cfg_ready}, {63'd0, !m_busy && (!cfg_w || w == W_CFG)});
      chk("resp_v", {63'd0, resp_v}, {63'd0, m_busy});
      if (m_busy) chk("resp_data", resp_data, m_resp);
      chk("w_mask", {56'd0, w_mask}, {56'd0, exp_mask(w)});
      chk("w_data", w_data, exp_data(w));
    end
  end

  task automatic next();
    @(posedge clk); #2;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  task automatic idle_inputs();
    ucode_v = 1'b0; ucode_mask = '0; ucode_data = '0;
    dir_v = 1'b0; dir_sel = '0; dir_addr = '0;
    cfg_v = 1'b0; cfg_w = 1'b0; cfg_sel = '0; cfg_data = '0; resp_yumi = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    next(); next();
    rst_n = 1'b1;
  endtask

  initial begin
    idle_inputs();
    rst_n = 1'b0;
    next();
    mid();
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_yumi", {63'd0, dir_yumi}, 64'd0);
    chk("rst_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rst_resp_v", {63'd0, resp_v}, 64'd0);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_mask", {56'd0, w_mask}, 64'd0);
    chk("rst_data", w_data, 64'd0);
    next();
    rst_n = 1'b1;
    #1 chk("ready_after_rst", {63'd0, cfg_ready}, 64'd1);
    next();

    // starvation: ucode streams while dir waits
    ucode_v = 1'b1; ucode_mask = 8'h01; ucode_data = 64'h0000_0000_0000_00A5;
    dir_v = 1'b1; dir_sel = 3'd3; dir_addr = 40'h00_8000_1000;
    for (int k = 1; k <= 5; k++) begin
      mid();
      if (k < 5) begin
        chk("starve_yumi_lo", {63'd0, dir_yumi}, 64'd0);
        chk("starve_stall_lo", {63'd0, stall}, 64'd0);
      end else begin
        chk("starve_stall_hi", {63'd0, stall}, 64'd1);
        chk("starve_yumi_hi", {63'd0, dir_yumi}, 64'd1);
        chk("starve_mask", {56'd0, w_mask}, 64'h08);
        chk("starve_data", w_data, 64'h0000_0000_8000_1000);
      end
    end
    next();
    mid();
    chk("stall_one_cycle", {63'd0, stall}, 64'd0);
    next();
    idle_inputs();
    next();

    // round robin between dir and cfg writes
    do_reset();
    dir_v = 1'b1; dir_sel = 3'd5; dir_addr = 40'h12_3456_789A;
    cfg_v = 1'b1; cfg_w = 1'b1; cfg_sel = 3'd6; cfg_data = 64'hCAFE_F00D_0000_0001;
    mid();
    chk("rr1_yumi", {63'd0, dir_yumi}, 64'd1);
    chk("rr1_ready", {63'd0, cfg_ready}, 64'd0);
    chk("rr1_data", w_data, 64'h0000_0012_3456_789A);
    next();
    dir_addr = 40'h00_0000_0042;
    mid();
    chk("rr2_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rr2_yumi", {63'd0, dir_yumi}, 64'd0);
    chk("rr2_mask", {56'd0, w_mask}, 64'h40);
    next();
    cfg_v = 1'b0; resp_yumi = 1'b1;
    mid();
    chk("rr3_resp_v", {63'd0, resp_v}, 64'd1);
    chk("rr3_resp_data", resp_data, 64'd0);
    chk("rr3_yumi", {63'd0, dir_yumi}, 64'd1);
    next();
    resp_yumi = 1'b0; cfg_v = 1'b1; cfg_sel = 3'd7; cfg_data = 64'h0000_0000_0000_0777;
    mid();
    chk("rr4_ready", {63'd0, cfg_ready}, 64'd1);
    chk("rr4_yumi", {63'd0, dir_yumi}, 64'd0);
    chk("rr4_mask", {56'd0, w_mask}, 64'h80);
    next();
    dir_v = 1'b0; cfg_v = 1'b0; resp_yumi = 1'b1;
    next();
    idle_inputs();
    next();

    // read of GPR2 racing a ucode write of GPR2, then a long-held response
    ucode_v = 1'b1; ucode_mask = 8'h04; ucode_data = 64'hBEEF;
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_sel = 3'd2;
    mid();
    chk("raw_ready", {63'd0, cfg_ready}, 64'd1);
    chk("raw_mask", {56'd0, w_mask}, 64'h04);
    next();
    ucode_v = 1'b0; ucode_mask = '0;
    for (int k = 0; k < 10; k++) begin
      mid();
      chk("hold_resp_v", {63'd0, resp_v}, 64'd1);
      chk("hold_resp_data", resp_data, 64'hDEAD);
      chk("hold_ready", {63'd0, cfg_ready}, 64'd0);
      next();
    end
    cfg_v = 1'b0; resp_yumi = 1'b1;
    next();
    resp_yumi = 1'b0; cfg_v = 1'b1; cfg_sel = 3'd2;
    next();
    cfg_v = 1'b0;
    mid();
    chk("readback_gpr2", resp_data, 64'hBEEF);
    next();
    resp_yumi = 1'b1;
    next();
    resp_yumi = 1'b0;
    next();

    // asynchronous reset while a response is pending
    cfg_v = 1'b1; cfg_w = 1'b0; cfg_sel = 3'd1;
    mid();
    chk("ar_ready", {63'd0, cfg_ready}, 64'd1);
    next();
    cfg_v = 1'b0;
    mid();
    chk("ar_resp_v", {63'd0, resp_v}, 64'd1);
    chk("ar_resp_data", resp_data, 64'h1111);
    rst_n = 1'b0;
    #1;
    chk("ar_resp_v_drop", {63'd0, resp_v}, 64'd0);
    chk("ar_resp_data_clr", resp_data, 64'd0);
    next(); next();
    rst_n = 1'b1;
    mid();
    chk("ar_idle_resp_v", {63'd0, resp_v}, 64'd0);
    chk("ar_idle_ready", {63'd0, cfg_ready}, 64'd1);
    next(); next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
